// File: rtl/fb_write_stage_if.sv
// Pixel handshake from the rasterizer plus the framebuffer write bus toward MultiSram.
interface fb_write_stage_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              pix_valid;
    logic [ADDR_W-1:0] pix_addr;
    logic [DATA_W-1:0] pix_data;
    logic              pix_ready;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_data;
    logic              gpu_write;
    logic              gpu_read;

    modport master (
        output pix_valid, pix_addr, pix_data,
        input  pix_ready, gpu_addr, gpu_data, gpu_write, gpu_read
    );

    modport slave (
        input  pix_valid, pix_addr, pix_data,
        output pix_ready, gpu_addr, gpu_data, gpu_write, gpu_read
    );
endinterface

// File: rtl/fb_write_stage.sv
// Buffers rasterized pixel writes and drains them to SRAM only while video is off.
// Optional framebuffer clear sweep is enabled by defining FB_CLEAR_EN.
module fb_write_stage #(
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int FB_WORDS = 76800
) (
    input  logic                     I_CLK,
    input  logic                     I_RST,
    input  logic                     I_VIDEO_ON,
`ifdef FB_CLEAR_EN
    input  logic                     I_CLEAR,
    input  logic [DATA_W-1:0]        I_CLEAR_COLOR,
`endif
    fb_write_stage_if.slave          bus,
    output logic [$clog2(DEPTH):0]   O_LEVEL,
    output logic [15:0]              O_DROP_CNT,
    output logic [15:0]              O_WRITE_CNT,
    output logic                     O_BUSY
);
    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_LEVEL = (PTR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;
`else
    typedef enum logic {IDLE, DRAIN} state_t;
`endif

    state_t                   state;
    logic [ADDR_W+DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W:0]           count;
    logic                     hold_valid;
    logic [ADDR_W-1:0]        hold_addr;
    logic [DATA_W-1:0]        hold_data;
    logic                     clearing;
    logic                     accept;
    logic                     in_range;
    logic                     push;
    logic                     pop;
    logic                     retire;

`ifdef FB_CLEAR_EN
    assign clearing = (state == CLEAR);
`else
    assign clearing = 1'b0;
`endif

    assign in_range      = (bus.pix_addr <= LAST_ADDR);
    assign bus.pix_ready = !I_RST && (count < FULL_LEVEL) && !clearing;
    assign accept        = bus.pix_valid && bus.pix_ready;
    assign push          = accept && in_range;
    assign retire        = bus.gpu_write;
    assign pop           = (count != '0) && (!hold_valid || retire) && !clearing;

    // Outputs are forced to their idle values combinationally during the reset cycle.
    assign bus.gpu_write = !I_RST && hold_valid && !I_VIDEO_ON;
    assign bus.gpu_addr  = I_RST ? '0 : hold_addr;
    assign bus.gpu_data  = I_RST ? '0 : hold_data;
    assign bus.gpu_read  = 1'b0;
    assign O_LEVEL       = I_RST ? '0 : count;
    assign O_BUSY        = !I_RST && ((count != '0) || hold_valid || clearing);

    always_ff @(posedge I_CLK) begin
        if (push) begin
            mem[wr_ptr] <= {bus.pix_addr, bus.pix_data};
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hold_valid  <= 1'b0;
            hold_addr   <= '0;
            hold_data   <= '0;
            O_DROP_CNT  <= '0;
            O_WRITE_CNT <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W + 1)'(1);
            end
            if (accept && !in_range) O_DROP_CNT <= O_DROP_CNT + 16'd1;
            if (retire)              O_WRITE_CNT <= O_WRITE_CNT + 16'd1;

            // The clear sweep reuses the hold register as its address/colour generator.
            if (!clearing) begin
                if (pop) begin
                    {hold_addr, hold_data} <= mem[rd_ptr];
                    hold_valid             <= 1'b1;
                end else if (retire) begin
                    hold_valid <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
`ifdef FB_CLEAR_EN
                    if (I_CLEAR) begin
                        state      <= CLEAR;
                        hold_valid <= 1'b1;
                        hold_addr  <= '0;
                        hold_data  <= I_CLEAR_COLOR;
                    end else if (push) begin
                        state <= DRAIN;
                    end
`else
                    if (push) state <= DRAIN;
`endif
                end
                DRAIN: begin
                    if ((count == '0) && retire && !push) state <= IDLE;
                end
`ifdef FB_CLEAR_EN
                CLEAR: begin
                    if (retire) begin
                        if (hold_addr == LAST_ADDR) begin
                            hold_valid <= 1'b0;
                            state      <= (count != '0) ? DRAIN : IDLE;
                        end else begin
                            hold_addr <= hold_addr + ADDR_W'(1);
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_write_stage.sv
// Self-checking bench for fb_write_stage: vector table, scoreboard monitor, multi-cycle sequences.
`timescale 1ns/1ps
module tb_fb_write_stage;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 18;
    localparam int DATA_W   = 16;
    localparam int FB_WORDS = 76800;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                drop;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        video_on = 1'b0;
    logic [4:0]  level;
    logic [15:0] drop_cnt;
    logic [15:0] write_cnt;
    logic        busy;

    int  total = 0;
    int  bad   = 0;
    int  seq   = 0;
    wr_t exp_q[$];

    fb_write_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_write_stage #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS)
    ) dut (
        .I_CLK(clk),
        .I_RST(rst),
        .I_VIDEO_ON(video_on),
`ifdef FB_CLEAR_EN
        .I_CLEAR(1'b0),
        .I_CLEAR_COLOR(16'h0000),
`endif
        .bus(bus),
        .O_LEVEL(level),
        .O_DROP_CNT(drop_cnt),
        .O_WRITE_CNT(write_cnt),
        .O_BUSY(busy)
    );

`ifdef FB_CLEAR_EN
    logic        clr = 1'b0;
    logic [15:0] clr_color = 16'h0000;
    logic [4:0]  c_level;
    logic [15:0] c_drop;
    logic [15:0] c_wcnt;
    logic        c_busy;

    fb_write_stage_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cbus ();

    fb_write_stage #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(8)
    ) cdut (
        .I_CLK(clk),
        .I_RST(rst),
        .I_VIDEO_ON(video_on),
        .I_CLEAR(clr),
        .I_CLEAR_COLOR(clr_color),
        .bus(cbus),
        .O_LEVEL(c_level),
        .O_DROP_CNT(c_drop),
        .O_WRITE_CNT(c_wcnt),
        .O_BUSY(c_busy)
    );
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every SRAM write must match the oldest pixel still owed to the framebuffer.
    always @(negedge clk) begin
        if (bus.gpu_write) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         bus.gpu_addr, bus.gpu_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.gpu_addr), 32'(e.addr));
                check("write_data", 32'(bus.gpu_data), 32'(e.data));
            end
        end
    end

    task automatic push_one(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit owed);
        int n = 0;
        wr_t e;
        bus.pix_valid = 1'b1;
        bus.pix_addr  = a;
        bus.pix_data  = d;
        while (!bus.pix_ready && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.pix_ready) begin
            bus.pix_valid = 1'b0;
            total++;
            bad++;
            $display("FAIL push_timeout: got ready=0 expected ready=1 within 64 cycles");
        end else begin
            if (owed) begin
                e.addr = a;
                e.data = d;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            bus.pix_valid = 1'b0;
        end
    endtask

    // Offers up to max_send pixels back-to-back and reports what was accepted and written.
    task automatic stream(input int cycles, input int max_send, output int sent, output int writes,
                          output int lvl_lo, output int lvl_hi);
        sent   = 0;
        writes = 0;
        lvl_lo = 1000;
        lvl_hi = -1;
        for (int c = 0; c < cycles; c++) begin
            bit  acc;
            wr_t e;
            bus.pix_valid = (sent < max_send);
            bus.pix_addr  = ADDR_W'(32'h100 + seq);
            bus.pix_data  = DATA_W'(32'hA000 + seq * 3);
            acc = bus.pix_valid && bus.pix_ready;
            if (acc) begin
                e.addr = bus.pix_addr;
                e.data = bus.pix_data;
                exp_q.push_back(e);
            end
            @(negedge clk);
            if (bus.gpu_write) writes++;
            if (int'(level) < lvl_lo) lvl_lo = int'(level);
            if (int'(level) > lvl_hi) lvl_hi = int'(level);
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                seq++;
            end
        end
        bus.pix_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (busy || exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got busy=%0b pending=%0d expected busy=0 pending=0",
                     busy, exp_q.size());
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   w_exp;
        int   d_exp;
        int   sent, wr, lo, hi;

        vecs[0] = '{18'h00000, 16'h1234, 1'b0};
        vecs[1] = '{18'd76799, 16'hBEEF, 1'b0};
        vecs[2] = '{18'd76800, 16'hDEAD, 1'b1};
        vecs[3] = '{18'h3FFFF, 16'hCAFE, 1'b1};
        vecs[4] = '{18'h12345, 16'h0F0F, 1'b0};
        vecs[5] = '{18'h12345, 16'hF0F0, 1'b0};

        bus.pix_valid = 1'b0;
        bus.pix_addr  = '0;
        bus.pix_data  = '0;
`ifdef FB_CLEAR_EN
        cbus.pix_valid = 1'b0;
        cbus.pix_addr  = '0;
        cbus.pix_data  = '0;
`endif

        // Reset cycle outputs
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_write", 32'(bus.gpu_write), 32'(0));
        check("rst_addr",  32'(bus.gpu_addr),  32'(0));
        check("rst_data",  32'(bus.gpu_data),  32'(0));
        check("rst_level", 32'(level),         32'(0));
        check("rst_busy",  32'(busy),          32'(0));
        check("rst_ready", 32'(bus.pix_ready), 32'(0));
        check("gpu_read",  32'(bus.gpu_read),  32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(bus.pix_ready), 32'(1));
        check("post_rst_drop",  32'(drop_cnt),      32'(0));
        check("post_rst_wcnt",  32'(write_cnt),     32'(0));
        w_exp = 0;
        d_exp = 0;

        // Two-cycle latency from acceptance to write
        @(posedge clk); #1;
        push_one(18'h00010, 16'hF00F, 1'b1);
        @(negedge clk);
        check("lat_c1_write", 32'(bus.gpu_write), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_c2_write", 32'(bus.gpu_write), 32'(1));
        check("lat_c2_addr",  32'(bus.gpu_addr),  32'(18'h00010));
        check("lat_c2_data",  32'(bus.gpu_data),  32'(16'hF00F));
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_c3_write", 32'(bus.gpu_write), 32'(0));
        check("lat_wcnt",     32'(write_cnt),     32'(1));
        check("lat_busy",     32'(busy),          32'(0));
        w_exp = 1;

        // Vector table: range boundary, out-of-range drops, repeated address
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            push_one(vecs[i].addr, vecs[i].data, !vecs[i].drop);
            if (vecs[i].drop) d_exp++;
            else              w_exp++;
            @(negedge clk);
            check("vec_drop_cnt", 32'(drop_cnt), 32'(d_exp));
            check("vec_ready",    32'(bus.pix_ready), 32'(1));
            @(posedge clk); #1;
        end
        wait_idle();
        check("vec_wcnt", 32'(write_cnt), 32'(w_exp));

        // Stall under active video: 16 in the FIFO plus one in the hold register
        video_on = 1'b1;
        stream(20, 20, sent, wr, lo, hi);
        check("stall_accepted", 32'(sent), 32'(17));
        check("stall_writes",   32'(wr),   32'(0));
        @(negedge clk);
        check("stall_level", 32'(level),         32'(16));
        check("stall_ready", 32'(bus.pix_ready), 32'(0));
        @(posedge clk); #1;
        video_on = 1'b0;
        stream(20, 3, sent, wr, lo, hi);
        check("release_accepted", 32'(sent), 32'(3));
        check("release_writes",   32'(wr),   32'(20));
        wait_idle();
        w_exp += 20;
        check("release_wcnt", 32'(write_cnt), 32'(w_exp));

        // Hold entry survives a video-on window and is written once
        @(posedge clk); #1;
        push_one(18'h02222, 16'h5A5A, 1'b1);
        @(posedge clk); #1;
        video_on = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_write", 32'(bus.gpu_write), 32'(0));
            check("hold_addr",  32'(bus.gpu_addr),  32'(18'h02222));
            check("hold_data",  32'(bus.gpu_data),  32'(16'h5A5A));
            @(posedge clk); #1;
        end
        video_on = 1'b0;
        @(negedge clk);
        check("hold_release_write", 32'(bus.gpu_write), 32'(1));
        @(posedge clk); #1;
        @(negedge clk);
        check("hold_after_write", 32'(bus.gpu_write), 32'(0));
        w_exp++;
        check("hold_wcnt", 32'(write_cnt), 32'(w_exp));

        // Full FIFO, then sustained push-and-pop; level holds once one slot has freed
        @(posedge clk); #1;
        video_on = 1'b1;
        stream(20, 17, sent, wr, lo, hi);
        check("fill_accepted", 32'(sent), 32'(17));
        video_on = 1'b0;
        stream(1, 0, sent, wr, lo, hi);
        stream(10, 10, sent, wr, lo, hi);
        check("pp_accepted", 32'(sent), 32'(10));
        check("pp_writes",   32'(wr),   32'(10));
        check("pp_level_lo", 32'(lo),   32'(15));
        check("pp_level_hi", 32'(hi),   32'(15));

        // Reset mid-stream abandons everything still queued
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("midrst_write", 32'(bus.gpu_write), 32'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_level_next", 32'(level),     32'(0));
        check("midrst_write_next", 32'(bus.gpu_write), 32'(0));
        check("midrst_wcnt",       32'(write_cnt), 32'(0));
        check("midrst_busy",       32'(busy),      32'(0));
        repeat (10) @(posedge clk);
        #1;

`ifdef FB_CLEAR_EN
        // Clear sweep on an 8-word framebuffer
        clr_color = 16'h0000;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("clr_write", 32'(cbus.gpu_write), 32'(1));
            check("clr_addr",  32'(cbus.gpu_addr),  32'(k));
            check("clr_data",  32'(cbus.gpu_data),  32'(clr_color));
            check("clr_ready", 32'(cbus.pix_ready), 32'(0));
            check("clr_busy",  32'(c_busy),         32'(1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("clr_done_write", 32'(cbus.gpu_write), 32'(0));
        check("clr_done_ready", 32'(cbus.pix_ready), 32'(1));
        check("clr_done_busy",  32'(c_busy),         32'(0));
        check("clr_wcnt",       32'(c_wcnt),         32'(8));
        @(posedge clk); #1;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
